vga_scan_generator: RTL
=======================

VGA_SCAN_GENERATOR -- requirements
Module: vga_scan_generator

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_VIS 640: visible pixels per line.
- H_FP 16: horizontal front porch.
- H_SYNC 96: horizontal sync width.
- H_BP 48: horizontal back porch.
- V_VIS 480: visible lines.
- V_FP 10: vertical front porch.
- V_SYNC 2: vertical sync width.
- V_BP 33: vertical back porch.
REQ-002 Ports, one per line: name, direction, width, meaning.
- Clk, in, 1: system clock (50 MHz).
- Reset, in, 1: reset, asynchronous, active-high.
- Red/Green/Blue, in, 8 each: pixel colour from the color mapper for the current DrawX/DrawY.
- DrawX, out, 10: current horizontal pixel coordinate.
- DrawY, out, 10: current vertical line coordinate.
- pix_en, out, 1: pixel-rate enable.
- VGA_HS, out, 1: horizontal sync, active-low.
- VGA_VS, out, 1: vertical sync, active-low.
- VGA_BLANK_N, out, 1: 1 in visible area, 0 in blanking.
- VGA_R/VGA_G/VGA_B, out, 8 each: registered pixel colour.
- frame_start, out, 1: one-Clk pulse at frame wrap.

Function
REQ-003 The design is one clock domain on Clk, and everything else is synchronous except Reset.
REQ-004 pix_en shall be a register that toggles every Clk edge, so it is high on every second cycle.
REQ-005 The horizontal counter hc (0..H_TOT-1, H_TOT=800) shall advance only on Clk edges where pix_en=1, and shall wrap from 799 to 0.
REQ-006 The vertical counter vc (0..V_TOT-1, V_TOT=525) shall increment only when hc wraps, and shall wrap from 524 to 0.
REQ-007 DrawX shall equal hc and DrawY shall equal vc, driven straight from the counter registers.
- DrawX covers 0..799 and DrawY covers 0..524.
- The color mapper treats coordinates at or beyond 640 and 480 as don't-care.
REQ-008 Define visible = (hc < H_VIS) and (vc < V_VIS).
REQ-009 Define hs_raw = 0 when H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC (656..751), else 1.
REQ-010 Define vs_raw = 0 when V_VIS+V_FP <= vc < V_VIS+V_FP+V_SYNC (490..491), else 1.
REQ-011 Output stage: on each pix_en edge, the block shall register:
- VGA_HS <= hs_raw;
- VGA_VS <= vs_raw;
- VGA_BLANK_N <= visible;
- VGA_R/G/B <= visible ? Red/Green/Blue : 0.
REQ-012 Latency: all VGA_* outputs shall lag DrawX/DrawY by exactly one pixel tick (2 Clk cycles), so sync and colour stay aligned.
REQ-013 Outside the visible area, VGA_R/G/B shall be 0 whatever the inputs are.
REQ-014 frame_start shall be high for exactly one Clk cycle: the cycle right after the pix_en edge on which (hc,vc) goes from (799,524) to (0,0).
REQ-015 Counter arithmetic is unsigned 10-bit, and counters shall never hold values at or above H_TOT or V_TOT.
REQ-016 Simultaneous wrap of hc and vc shall produce (0,0) in a single pixel tick, with no intermediate (0,525) state.
REQ-017 Red/Green/Blue shall be sampled only on pix_en edges; changes between those edges have no effect.

Reset
REQ-018 While Reset=1, the block shall hold these values:
- pix_en=0, hc=0, vc=0, so DrawX=0 and DrawY=0;
- VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0;
- VGA_R/G/B=0, frame_start=0.
REQ-019 Reset asserted mid-frame shall force the REQ-018 values immediately, without waiting for a Clk edge.
REQ-020 After Reset deasserts, the first pix_en=1 shall occur after the first Clk edge, and counting starts from (0,0).

Verification
REQ-021 Reset check: assert Reset mid-line at hc=300, vc=100.
- Required: all outputs take REQ-018 values asynchronously, before the next Clk edge.
- After release, DrawX steps 0,1,2 on successive pix_en edges.
REQ-022 Line timing check: run one line.
- Required: VGA_HS is low for exactly 96 pixel ticks, starting one tick after DrawX=656.
- Required: the line period is 800 ticks (1600 Clk).
REQ-023 Frame timing check: run one frame.
- Required: VGA_VS is low for exactly 2 lines (lines 490..491, delayed one tick).
- Required: frame_start pulses once per 420000 pixel ticks (840000 Clk), each pulse one Clk wide.
REQ-024 Blanking check: hold Red=Green=Blue=8'hFF.
- Required: VGA_R/G/B = FF exactly when VGA_BLANK_N=1, and 00 otherwise.
- Required: VGA_BLANK_N=1 for 640x480 = 307200 ticks per frame.
REQ-025 Alignment check: drive Red = DrawX[7:0] combinationally, as a colour-mapper model.
- Required: VGA_R at tick t equals the DrawX value at tick t-1, for every visible pixel.
REQ-026 Wrap check: step to (799,524).
- Required: the next pix_en edge gives (0,0) with no out-of-range value.
- Required: frame_start=1 for exactly that one cycle.

Source files
------------

// File: rtl/vga_scan_generator.sv
// VGA scan generator: half-rate pixel enable, horizontal/vertical raster
// counters, active-low syncs, blanking and a registered colour output stage.
// All VGA_* outputs are registered one pixel tick behind DrawX/DrawY so that
// sync, blank and colour from the colour mapper line up at the connector.
module vga_scan_generator #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pix_en,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  // Raster boundaries as 10-bit constants so every compare is width-matched
  localparam logic [9:0] H_LAST       = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C      = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C      = 10'(V_VIS);
  localparam logic [9:0] H_SYNC_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic       r_pixEn;
  logic [9:0] r_hc;
  logic [9:0] r_vc;
  logic       r_hs;
  logic       r_vs;
  logic       r_blankN;
  logic [7:0] r_red;
  logic [7:0] r_green;
  logic [7:0] r_blue;
  logic       r_frameStart;

  logic w_hWrap;
  logic w_vWrap;
  logic w_visible;
  logic w_hsRaw;
  logic w_vsRaw;

  // Wrap detection uses >= so a counter can never run past its last value
  assign w_hWrap   = (r_hc >= H_LAST);
  assign w_vWrap   = (r_vc >= V_LAST);
  assign w_visible = (r_hc < H_VIS_C) && (r_vc < V_VIS_C);
  assign w_hsRaw   = !((r_hc >= H_SYNC_START) && (r_hc < H_SYNC_END));
  assign w_vsRaw   = !((r_vc >= V_SYNC_START) && (r_vc < V_SYNC_END));

  // Pixel enable toggles every clock, giving one pixel tick per two clocks
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pixEn <= 1'b0;
    end else begin
      r_pixEn <= ~r_pixEn;
    end
  end

  // Raster counters; both wrap together in one tick at the end of a frame
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (r_pixEn) begin
      if (w_hWrap) begin
        r_hc <= '0;
        if (w_vWrap) begin
          r_vc <= '0;
        end else begin
          r_vc <= r_vc + 10'd1;
        end
      end else begin
        r_hc <= r_hc + 10'd1;
      end
    end
  end

  // Output stage samples the current position and colour one tick behind the counters
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
      r_blankN <= 1'b0;
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
    end else if (r_pixEn) begin
      r_hs     <= w_hsRaw;
      r_vs     <= w_vsRaw;
      r_blankN <= w_visible;
      r_red    <= w_visible ? Red   : 8'd0;
      r_green  <= w_visible ? Green : 8'd0;
      r_blue   <= w_visible ? Blue  : 8'd0;
    end
  end

  // Frame pulse is raised on the tick that wraps to (0,0) and cleared on the next clock
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_frameStart <= 1'b0;
    end else begin
      r_frameStart <= r_pixEn && w_hWrap && w_vWrap;
    end
  end

  assign pix_en      = r_pixEn;
  assign DrawX       = r_hc;
  assign DrawY       = r_vc;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blankN;
  assign VGA_R       = r_red;
  assign VGA_G       = r_green;
  assign VGA_B       = r_blue;
  assign frame_start = r_frameStart;

endmodule
